// File: rtl/hid_event_sequencer.sv
// hid_event_sequencer
//
// Turns successive HID boot-keyboard reports into a stream of single key
// press/release events. Each completed report (signalled by a toggle on
// new_packet) is snapshotted into cur and diffed against the last committed
// report (prev). Events are emitted in this order:
//   1. modifier releases
//   2. key releases
//   3. modifier presses
//   4. key presses
// Within each group the order is ascending index. prev is updated only when a
// scan finishes. A report containing the rollover error code is discarded.
// When the link is lost, every held key is released.
//
// Ports
//   usbclk     in   12 MHz clock; all state changes on its rising edge
//   usbrst_n   in   synchronous active-low reset
//   key0       in   modifier bitmap of the latest report
//   key1..key6 in   keycode slots 1-6, 0 = empty
//   new_packet in   toggles once per completed report
//   conerr     in   high while the USB link is lost or in reset
//   ev_valid   out  an event is offered
//   ev_ready   in   consumer accepts the offered event
//   ev_code    out  event keycode (0 when no event is offered)
//   ev_press   out  1 = press, 0 = release
//   busy       out  sequencer is not idle
//
// The event outputs are a pure decode of registered state. There is no
// combinational path from any input to any output. The outputs stay stable
// until the handshake completes because the decoded registers only change
// on an accept.

module hid_event_sequencer #(
    parameter logic [7:0] ERR_CODE = 8'h01,
    parameter logic [7:0] MOD_BASE = 8'hE0
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic [7:0] key0,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    input  logic [7:0] key5,
    input  logic [7:0] key6,
    input  logic       new_packet,
    input  logic       conerr,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_press,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StRelMod,
        StRelKey,
        StPrsMod,
        StPrsKey,
        StCommit
    } state_e;

    state_e          state_q;
    logic [2:0]      idx_q;
    // Slot 0 holds the modifier bitmap; slots 1-6 hold keycodes.
    logic [6:0][7:0] cur_q;
    logic [6:0][7:0] prev_q;
    logic            pending_q;
    logic            new_packet_q;

    logic [6:0][7:0] keys;
    logic            report_edge;

    logic            err_snap;
    logic [7:0]      sel_prev;
    logic [7:0]      sel_cur;
    logic            prev_in_cur;
    logic            prev_earlier;
    logic            cur_in_prev;
    logic            cur_earlier;
    logic            hit;
    logic [7:0]      code;
    logic            press;
    logic            last_idx;
    state_e          next_scan;

    assign keys        = {key6, key5, key4, key3, key2, key1, key0};
    assign report_edge = new_packet ^ new_packet_q;

    always_comb begin
        err_snap = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            if (cur_q[j] == ERR_CODE) err_snap = 1'b1;
        end

        // In the key states, scan index i addresses slot i + 1.
        sel_prev = 8'h00;
        sel_cur  = 8'h00;
        for (int j = 1; j <= 6; j++) begin
            if (idx_q == 3'(j - 1)) begin
                sel_prev = prev_q[j];
                sel_cur  = cur_q[j];
            end
        end

        prev_in_cur  = 1'b0;
        prev_earlier = 1'b0;
        cur_in_prev  = 1'b0;
        cur_earlier  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (cur_q[k] == sel_prev) prev_in_cur = 1'b1;
            if (prev_q[k] == sel_cur) cur_in_prev = 1'b1;
            // A duplicate in an earlier slot already produced this key's event.
            if (3'(k - 1) < idx_q) begin
                if (prev_q[k] == sel_prev) prev_earlier = 1'b1;
                if (cur_q[k] == sel_cur)   cur_earlier  = 1'b1;
            end
        end

        hit       = 1'b0;
        code      = 8'h00;
        press     = 1'b0;
        last_idx  = 1'b0;
        next_scan = StIdle;
        unique case (state_q)
            StRelMod: begin
                last_idx  = (idx_q == 3'd7);
                next_scan = StRelKey;
                hit       = prev_q[0][idx_q] & ~cur_q[0][idx_q];
                code      = MOD_BASE + {5'd0, idx_q};
            end
            StRelKey: begin
                last_idx  = (idx_q == 3'd5);
                next_scan = StPrsMod;
                hit       = (sel_prev != 8'h00) && !prev_in_cur && !prev_earlier;
                code      = sel_prev;
            end
            StPrsMod: begin
                last_idx  = (idx_q == 3'd7);
                next_scan = StPrsKey;
                hit       = cur_q[0][idx_q] & ~prev_q[0][idx_q];
                code      = MOD_BASE + {5'd0, idx_q};
                press     = 1'b1;
            end
            StPrsKey: begin
                last_idx  = (idx_q == 3'd5);
                next_scan = StCommit;
                hit       = (sel_cur != 8'h00) && !cur_in_prev && !cur_earlier;
                code      = sel_cur;
                press     = 1'b1;
            end
            default: ;
        endcase
    end

    // An error snapshot never offers an event. It leaves REL_MOD on its first cycle.
    assign ev_valid = hit & ~err_snap;
    assign ev_code  = ev_valid ? code : 8'h00;
    assign ev_press = ev_valid & press;
    assign busy     = (state_q != StIdle);

    always_ff @(posedge usbclk) begin
        if (!usbrst_n) begin
            state_q      <= StIdle;
            idx_q        <= 3'd0;
            cur_q        <= '0;
            prev_q       <= '0;
            pending_q    <= 1'b0;
            new_packet_q <= new_packet;
        end else begin
            new_packet_q <= new_packet;

            // A fresh edge wins over the clear from servicing the previous report.
            if (conerr) begin
                pending_q <= 1'b0;
            end else if (report_edge) begin
                pending_q <= 1'b1;
            end else if (state_q == StIdle) begin
                pending_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    idx_q <= 3'd0;
                    if (conerr) begin
                        if (prev_q != '0) begin
                            cur_q   <= '0;
                            state_q <= StRelMod;
                        end
                    end else if (pending_q) begin
                        cur_q   <= keys;
                        state_q <= StRelMod;
                    end
                end
                StCommit: begin
                    prev_q  <= cur_q;
                    idx_q   <= 3'd0;
                    state_q <= StIdle;
                end
                default: begin
                    if (state_q == StRelMod && err_snap) begin
                        idx_q   <= 3'd0;
                        state_q <= StIdle;
                    end else if (!ev_valid || ev_ready) begin
                        if (last_idx) begin
                            idx_q   <= 3'd0;
                            state_q <= next_scan;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hid_event_sequencer.sv
// Self-checking bench for hid_event_sequencer.
// The reference model diffs two reports as sets. It produces the expected
// event list, and a monitor checks every offered event against it.
module tb_hid_event_sequencer;

    logic       usbclk;
    logic       usbrst_n;
    logic [7:0] key0, key1, key2, key3, key4, key5, key6;
    logic       new_packet;
    logic       conerr;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_press;
    logic       busy;

    hid_event_sequencer dut (
        .usbclk     (usbclk),
        .usbrst_n   (usbrst_n),
        .key0       (key0),
        .key1       (key1),
        .key2       (key2),
        .key3       (key3),
        .key4       (key4),
        .key5       (key5),
        .key6       (key6),
        .new_packet (new_packet),
        .conerr     (conerr),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_code    (ev_code),
        .ev_press   (ev_press),
        .busy       (busy)
    );

    initial begin
        usbclk = 1'b0;
        forever #5 usbclk = ~usbclk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Event encoding: {press, code}
    logic [8:0]      exp_q[$];
    logic [8:0]      tmp_q[$];
    logic [6:0][7:0] model_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [6:0][7:0] mk(input logic [7:0] k0, input logic [7:0] k1,
                                           input logic [7:0] k2, input logic [7:0] k3,
                                           input logic [7:0] k4, input logic [7:0] k5,
                                           input logic [7:0] k6);
        return {k6, k5, k4, k3, k2, k1, k0};
    endfunction

    function automatic bit has_err(input logic [6:0][7:0] r);
        for (int j = 1; j <= 6; j++) if (r[j] == 8'h01) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit key_in(input logic [6:0][7:0] r, input logic [7:0] c);
        for (int j = 1; j <= 6; j++) if (r[j] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Set difference: releases = held before and not now; presses = now and not before.
    task automatic compute(input logic [6:0][7:0] p, input logic [6:0][7:0] c);
        logic [7:0] done_q[$];
        tmp_q.delete();
        if (has_err(c)) return;
        for (int i = 0; i < 8; i++)
            if (p[0][i] && !c[0][i]) tmp_q.push_back({1'b0, 8'hE0 + 8'(i)});
        done_q.delete();
        for (int j = 1; j <= 6; j++) begin
            if (p[j] != 8'h00 && !key_in(c, p[j]) && !(p[j] inside {done_q})) begin
                tmp_q.push_back({1'b0, p[j]});
                done_q.push_back(p[j]);
            end
        end
        for (int i = 0; i < 8; i++)
            if (c[0][i] && !p[0][i]) tmp_q.push_back({1'b1, 8'hE0 + 8'(i)});
        done_q.delete();
        for (int j = 1; j <= 6; j++) begin
            if (c[j] != 8'h00 && !key_in(p, c[j]) && !(c[j] inside {done_q})) begin
                tmp_q.push_back({1'b1, c[j]});
                done_q.push_back(c[j]);
            end
        end
    endtask

    task automatic drive_keys(input logic [6:0][7:0] k);
        key0 = k[0]; key1 = k[1]; key2 = k[2]; key3 = k[3];
        key4 = k[4]; key5 = k[5]; key6 = k[6];
    endtask

    task automatic send_report(input logic [6:0][7:0] k);
        @(posedge usbclk);
        #1;
        drive_keys(k);
        new_packet = ~new_packet;
        compute(model_prev, k);
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        if (!has_err(k)) model_prev = k;
    endtask

    task automatic drain(input string name, input int cycles);
        repeat (cycles) @(posedge usbclk);
        @(negedge usbclk);
        check({name, "_drained"}, exp_q.size(), 0);
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        @(negedge usbclk);
        while (!ev_valid && n < budget) begin
            @(negedge usbclk);
            n++;
        end
        check({name, "_valid_seen"}, ev_valid, 1);
    endtask

    // Monitor: every offered event must be the next expected one and must hold while stalled.
    logic       held;
    logic [8:0] held_ev;
    initial begin
        held = 1'b0;
        held_ev = '0;
        forever begin
            @(negedge usbclk);
            if (!usbrst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", ev_valid, 1);
                    check("hold_event", {ev_press, ev_code}, held_ev);
                end
                held = 1'b0;
                if (ev_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_event: got %0h, expected no event",
                                 {ev_press, ev_code});
                    end else if (ev_ready) begin
                        check("event", {ev_press, ev_code}, exp_q.pop_front());
                    end else begin
                        held    = 1'b1;
                        held_ev = {ev_press, ev_code};
                    end
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        int gap;
        bit fell;
        bit rose_again;

        usbrst_n   = 1'b0;
        new_packet = 1'b0;
        conerr     = 1'b0;
        ev_ready   = 1'b1;
        model_prev = '0;
        drive_keys('0);
        repeat (3) @(posedge usbclk);
        #1 usbrst_n = 1'b1;

        // Reset state
        @(negedge usbclk);
        check("rst_ev_valid", ev_valid, 0);
        check("rst_ev_code", ev_code, 0);
        check("rst_ev_press", ev_press, 0);
        check("rst_busy", busy, 0);

        // Static new_packet: nothing happens
        for (int i = 0; i < 100; i++) begin
            @(negedge usbclk);
            check("quiet_valid", ev_valid, 0);
            check("quiet_busy", busy, 0);
        end

        // Single key press then release
        send_report(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        check("pin_single_len", tmp_q.size(), 1);
        check("pin_single_ev", tmp_q[0], 9'h104);
        drain("single_press", 40);
        send_report('0);
        check("pin_release_ev", tmp_q[0], 9'h004);
        drain("single_release", 40);

        // Duplicate slots produce a single event; a move between slots produces none
        send_report(mk(8'h00, 8'h04, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00));
        check("pin_dup_len", tmp_q.size(), 1);
        drain("dup_press", 40);
        send_report(mk(8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00));
        check("pin_move_len", tmp_q.size(), 0);
        drain("dup_move", 40);
        send_report('0);
        drain("dup_release", 40);

        // All modifiers down then up
        send_report(mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        check("pin_mod_last", tmp_q[7], 9'h1E7);
        drain("mod_press", 40);
        send_report('0);
        drain("mod_release", 40);

        // Release-before-press ordering
        send_report(mk(8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        drain("order_setup", 40);
        send_report(mk(8'h20, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00));
        check("pin_order_len", tmp_q.size(), 4);
        check("pin_order_0", tmp_q[0], 9'h0E1);
        check("pin_order_1", tmp_q[1], 9'h005);
        check("pin_order_2", tmp_q[2], 9'h1E5);
        check("pin_order_3", tmp_q[3], 9'h106);
        drain("order", 40);
        send_report('0);
        drain("order_clear", 40);

        // Rollover-error report is discarded
        send_report(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        drain("err_setup", 40);
        send_report(mk(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01));
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge usbclk);
            if (busy) busy_cnt++;
        end
        check("err_busy_le2", busy_cnt <= 2, 1);
        send_report('0);
        check("pin_err_release", tmp_q[0], 9'h004);
        drain("err_release", 40);

        // Stalled consumer plus a second report arriving mid-scan
        ev_ready = 1'b0;
        send_report(mk(8'h00, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_valid("stall", 60);
        repeat (3) @(posedge usbclk);
        send_report(mk(8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        check("pin_second_len", tmp_q.size(), 3);
        repeat (6) @(posedge usbclk);
        #1 ev_ready = 1'b1;
        gap = 0;
        fell = 1'b0;
        rose_again = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge usbclk);
            if (!rose_again) begin
                if (!busy && !fell) fell = 1'b1;
                if (!busy && fell) gap++;
                if (busy && fell) rose_again = 1'b1;
            end
        end
        check("second_rose", rose_again, 1);
        check("second_gap", gap, 1);
        check("second_drained", exp_q.size(), 0);
        send_report('0);
        drain("second_clear", 40);

        // Link loss releases held keys and ignores reports
        send_report(mk(8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
        drain("conerr_setup", 40);
        @(posedge usbclk);
        #1 conerr = 1'b1;
        compute(model_prev, '0);
        check("pin_conerr_ev", tmp_q[0], 9'h004);
        foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
        model_prev = '0;
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(posedge usbclk);
            #1;
            drive_keys(mk(8'h00, 8'h10 + 8'(i), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
            new_packet = ~new_packet;
        end
        drain("conerr", 40);
        @(posedge usbclk);
        #1 conerr = 1'b0;
        drain("conerr_after", 40);

        // Reset in the middle of a sequence aborts it
        ev_ready = 1'b0;
        send_report(mk(8'h00, 8'h09, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00));
        wait_valid("midrst", 60);
        @(posedge usbclk);
        #1 usbrst_n = 1'b0;
        exp_q.delete();
        model_prev = '0;
        repeat (2) @(posedge usbclk);
        #1 begin
            usbrst_n = 1'b1;
            ev_ready = 1'b1;
        end
        @(negedge usbclk);
        check("midrst_valid", ev_valid, 0);
        check("midrst_code", ev_code, 0);
        drain("midrst", 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hid_event_sequencer.md
HID_EVENT_SEQUENCER -- requirements
Module: hid_event_sequencer

Interface
REQ-001 SHALL have parameter ERR_CODE, default 8'h01, the keycode that marks a rollover-error report.
REQ-002 SHALL have parameter MOD_BASE, default 8'hE0, the event code for modifier bit 0; bit i maps to MOD_BASE+i.
REQ-003 SHALL have port usbclk, input, 1, the single 12 MHz clock; all logic is on its rising edge.
REQ-004 SHALL have port usbrst_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port key0, input, 8, the modifier bitmap of the latest report.
REQ-006 SHALL have ports key1..key6, input, 8 each, keycode slots 1-6; 0 means empty.
REQ-007 SHALL have port new_packet, input, 1, which toggles once per completed report.
REQ-008 SHALL have port conerr, input, 1, high while the USB link is lost or in reset.
REQ-009 SHALL have port ev_valid, output, 1, high while an event is offered.
REQ-010 SHALL have port ev_ready, input, 1, consumer accept.
REQ-011 SHALL have port ev_code, output, 8, the event keycode.
REQ-012 SHALL have port ev_press, output, 1: 1 = press, 0 = release.
REQ-013 SHALL have port busy, output, 1, high in any state except IDLE.

Function
REQ-014 SHALL register new_packet each cycle; a report edge is new_packet XOR its registered copy.
REQ-015 SHALL set a pending flag on a report edge in any state; several edges before service collapse to one.
REQ-016 SHALL, in IDLE with pending set and conerr low, copy key0..key6 into a cur snapshot, clear pending, and enter REL_MOD the next cycle.
REQ-017 SHALL discard a snapshot with any of key1..key6 equal to ERR_CODE: return to IDLE, keep prev unchanged, emit no events.
REQ-018 SHALL, in IDLE with conerr high and prev non-zero, load cur with all zeros and enter REL_MOD.
REQ-019 SHALL, while conerr is high, clear pending every cycle so that report edges are ignored.
REQ-020 SHALL use states IDLE, REL_MOD, REL_KEY, PRS_MOD, PRS_KEY, COMMIT, with a 3-bit scan index reset to 0 on entry to each scan state.
REQ-021 SHALL in REL_MOD, for i = 0..7, release MOD_BASE+i when prev bit i = 1 and cur bit i = 0.
REQ-022 SHALL in REL_KEY, for j = 1..6, release prev[j] when prev[j] != 0, no cur slot equals it, and no prev slot k < j equals it.
REQ-023 SHALL in PRS_MOD, for i = 0..7, press MOD_BASE+i when cur bit i = 1 and prev bit i = 0.
REQ-024 SHALL in PRS_KEY, for j = 1..6, press cur[j] when cur[j] != 0, no prev slot equals it, and no cur slot k < j equals it.
REQ-025 SHALL spend exactly one cycle on an index that produces no event.
REQ-026 SHALL, on an index that produces an event, assert ev_valid with ev_code and ev_press and hold all three stable until a cycle with ev_valid and ev_ready both high; the index advances on that cycle.
REQ-027 SHALL, on the last index of a state, advance REL_MOD -> REL_KEY -> PRS_MOD -> PRS_KEY -> COMMIT.
REQ-028 SHALL, in COMMIT, copy prev from cur, then enter IDLE the next cycle.
REQ-029 SHALL emit all releases before all presses, modifiers before keys, and ascending index within each group.
REQ-030 SHALL bound a full sequence, with ev_ready held high, to 1 + 8 + 6 + 8 + 6 + 1 = 30 cycles from snapshot to IDLE.
REQ-031 SHALL keep ev_valid low outside the four scan states.
REQ-032 SHALL NOT change ev_code or ev_press while ev_valid is high and ev_ready is low.
REQ-033 SHALL ignore key0..key6 changes during a scan, because cur is a snapshot.

Reset
REQ-034 SHALL, when usbrst_n is low at a clock edge, set state = IDLE, ev_valid = 0, ev_code = 0, ev_press = 0, busy = 0, pending = 0, prev = 0, cur = 0, scan index = 0, and the new_packet copy = new_packet.
REQ-035 SHALL, on reset mid-sequence, abort it with no further events and no commit.

Verification
REQ-036 SHALL cover: after reset, new_packet static for 100 cycles -> ev_valid = 0, busy = 0.
REQ-037 SHALL cover: key1 = 0x04, toggle -> exactly one event (0x04, press = 1); then all zero, toggle -> exactly one event (0x04, press = 0).
REQ-038 SHALL cover: prev key0 = 0x02, key1 = 0x05; new key0 = 0x20, key2 = 0x06 -> events in order E1/rel, 05/rel, E5/press, 06/press, then busy = 0.
REQ-039 SHALL cover: held key 0x04, then a report with key1..key6 = 0x01 -> no events, busy high for at most 2 cycles, next all-zero report -> 0x04 release.
REQ-040 SHALL cover: ev_ready low 10 cycles during the first event, and a second toggle mid-scan -> ev_code/ev_press stable throughout; the second report is processed right after COMMIT.
REQ-041 SHALL cover: key 0x04 held, conerr raised -> 0x04 release; toggles while conerr is high -> no events.
